// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs and latch/bubble/flush controls between the interlock and the pipeline.
interface pipeline_stall_ctrl_if;
  logic        load_use_hazard;
  logic [31:0] dx_insn;
  logic        branch_taken;
  logic        md_result_ready;
  logic        pc_we;
  logic        fd_we;
  logic        dx_we;
  logic        fd_flush;
  logic        dx_insert_nop;
  logic        xm_insert_nop;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        md_busy;
  logic        md_timeout;
  logic [15:0] stall_cycles;
  modport master (
    output load_use_hazard, dx_insn, branch_taken, md_result_ready,
    input  pc_we, fd_we, dx_we, fd_flush, dx_insert_nop, xm_insert_nop,
           ctrl_mult, ctrl_div, md_busy, md_timeout, stall_cycles
  );
  modport slave (
    input  load_use_hazard, dx_insn, branch_taken, md_result_ready,
    output pc_we, fd_we, dx_we, fd_flush, dx_insert_nop, xm_insert_nop,
           ctrl_mult, ctrl_div, md_busy, md_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: turns load-use, branch and mul/div status into latch enables, bubbles and flushes.
module pipeline_stall_ctrl #(
  parameter int MD_TIMEOUT = 64
) (
  input logic                  clock,
  input logic                  reset,
  pipeline_stall_ctrl_if.slave bus
);
  typedef enum logic {RUN, MD_WAIT} state_t;
  localparam logic [7:0] LAST_WAIT = 8'(MD_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        md_timeout_q, md_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        is_alu, is_mul, is_div, pc_we, unused_bits;
  assign is_alu = bus.dx_insn[31:27] == 5'b00000;
  assign is_mul = is_alu && bus.dx_insn[6:2] == 5'b00110;
  assign is_div = is_alu && bus.dx_insn[6:2] == 5'b00111;
  assign unused_bits = ^{bus.dx_insn[26:7], bus.dx_insn[1:0]};
  assign bus.pc_we        = pc_we;
  assign bus.md_busy      = !reset && state_q == MD_WAIT;
  assign bus.md_timeout   = md_timeout_q;
  assign bus.stall_cycles = stall_cycles_q;
  always_comb begin
    state_d           = state_q;
    wait_cnt_d        = wait_cnt_q;
    md_timeout_d      = md_timeout_q;
    pc_we             = 1'b1;
    bus.fd_we         = 1'b1;
    bus.dx_we         = 1'b1;
    bus.fd_flush      = 1'b0;
    bus.dx_insert_nop = 1'b0;
    bus.xm_insert_nop = 1'b0;
    bus.ctrl_mult     = 1'b0;
    bus.ctrl_div      = 1'b0;
    if (state_q == RUN) begin
      if (bus.branch_taken) begin
        bus.fd_flush      = 1'b1;
        bus.dx_insert_nop = 1'b1;
      end else if (is_mul || is_div) begin
        bus.ctrl_mult     = is_mul;
        bus.ctrl_div      = is_div;
        pc_we             = 1'b0;
        bus.fd_we         = 1'b0;
        bus.dx_we         = 1'b0;
        bus.xm_insert_nop = 1'b1;
        state_d           = MD_WAIT;
        wait_cnt_d        = 8'd0;
      end else if (bus.load_use_hazard) begin
        pc_we             = 1'b0;
        bus.fd_we         = 1'b0;
        bus.dx_insert_nop = 1'b1;
      end
    end else if (bus.md_result_ready || wait_cnt_q == LAST_WAIT) begin
      // release: the finished mul/div moves on to X/M; a missing ready means forced release
      state_d      = RUN;
      wait_cnt_d   = 8'd0;
      md_timeout_d = md_timeout_q || !bus.md_result_ready;
    end else begin
      pc_we             = 1'b0;
      bus.fd_we         = 1'b0;
      bus.dx_we         = 1'b0;
      bus.xm_insert_nop = 1'b1;
      wait_cnt_d        = wait_cnt_q + 8'd1;
    end
    if (reset) begin
      pc_we             = 1'b0;
      bus.fd_we         = 1'b0;
      bus.dx_we         = 1'b0;
      bus.fd_flush      = 1'b0;
      bus.dx_insert_nop = 1'b0;
      bus.xm_insert_nop = 1'b0;
      bus.ctrl_mult     = 1'b0;
      bus.ctrl_div      = 1'b0;
    end
    stall_cycles_d = (!pc_we && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= 8'd0;
      md_timeout_q   <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      md_timeout_q   <= md_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule
